mem_stage: RTL and testbench

- MEM stage of the 5-stage pipeline; sits directly downstream of the EX/MEM register and consumes its outputs: MEM_M, WB_M, ALUOut_M, WriteData_M, WriteReg_M.
- Drives a word-wide data-memory bus with a req/ready handshake that supports a variable number of wait states.
- Stalls the upstream pipeline while an access is outstanding and aborts hung accesses after a timeout.
- Contains the MEM/WB pipeline register that feeds writeback.

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
`timescale 1ns/1ps
// mem_stage_if
// Word-wide data-memory bus between the MEM stage and data memory.
// Uses a req/ready handshake. The memory may insert any number of wait states
// by holding dmem_ready low.
//   dmem_req    master->slave  access request
//   dmem_we     master->slave  1=write, 0=read
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_wdata  master->slave  store data
//   dmem_rdata  slave->master  load data, valid while dmem_ready=1
//   dmem_ready  slave->master  access completes this cycle
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage
// MEM stage of the 5-stage pipeline. It takes the EX/MEM register outputs and
// issues data-memory accesses over a req/ready bus. While an access waits on
// memory, it stalls the upstream pipeline. An access still waiting after
// TIMEOUT wait-state cycles is aborted. The stage also holds the MEM/WB
// pipeline register.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   MEM_M, WB_M             memory control {MemRead,MemWrite}, WB control {RegWrite,MemtoReg}
//   ALUOut_M, WriteData_M   effective address / ALU result, store data
//   WriteReg_M              destination register
//   dmem                    data-memory bus (master side)
//   StallM                  freezes PC, IF/ID, ID/EX and EX/MEM
//   WB_W, ReadData_W, ALUOut_W, WriteReg_W, BusErr_W   MEM/WB register outputs
//   StallCount              saturating count of StallM cycles
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       MEM_M,
    input  logic [1:0]       WB_M,
    input  logic [31:0]      ALUOut_M,
    input  logic [31:0]      WriteData_M,
    input  logic [4:0]       WriteReg_M,
    mem_stage_if.master      dmem,
    output logic             StallM,
    output logic [1:0]       WB_W,
    output logic [31:0]      ReadData_W,
    output logic [31:0]      ALUOut_W,
    output logic [4:0]       WriteReg_W,
    output logic             BusErr_W,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam int             WCW        = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;

    logic op;
    logic illegal;
    logic req_int;
    logic stall_int;
    logic done;
    logic abort;
    logic squash;

    assign op      = MEM_M[1] | MEM_M[0];
    assign illegal = (MEM_M == 2'b11) || (op && (ALUOut_M[1:0] != 2'b00));

    // The EX/MEM outputs hold while StallM is high, so the request fields stay
    // stable during WAIT without a local copy.
    assign dmem.dmem_we    = MEM_M[0];
    assign dmem.dmem_addr  = ALUOut_M;
    assign dmem.dmem_wdata = WriteData_M;

    // Reset must drop the request and the stall at once, even while the
    // inputs still describe a valid access.
    assign dmem.dmem_req = req_int & rst_n;
    assign StallM        = stall_int & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op && !illegal && !dmem.dmem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmem_ready || (wait_cnt == WAIT_LIMIT)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_int   = 1'b0;
        stall_int = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                req_int = op & ~illegal;
                if (req_int && dmem.dmem_ready) begin
                    done = 1'b1;
                end else if (req_int) begin
                    stall_int = 1'b1;
                end
            end
            WAIT: begin
                req_int = 1'b1;
                if (dmem.dmem_ready) begin
                    done = 1'b1;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    abort = 1'b1;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The wait counter is 1 in the first WAIT cycle. The cycle that entered
    // WAIT from IDLE already counted as one wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next == IDLE) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= WCW'(1);
        end else begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Illegal ops are only judged in IDLE. In WAIT the inputs are those of an
    // access that was already accepted.
    assign squash = ((state == IDLE) && illegal) || abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_W       <= '0;
            ReadData_W <= '0;
            ALUOut_W   <= '0;
            WriteReg_W <= '0;
            BusErr_W   <= 1'b0;
        end else if (stall_int) begin
            WB_W     <= '0;
            BusErr_W <= 1'b0;
        end else begin
            ALUOut_W   <= ALUOut_M;
            WriteReg_W <= WriteReg_M;
            if (squash) begin
                WB_W     <= '0;
                BusErr_W <= 1'b1;
            end else begin
                WB_W     <= WB_M;
                BusErr_W <= 1'b0;
            end
            if (done && MEM_M[1]) begin
                ReadData_W <= dmem.dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (stall_int && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// tb_mem_stage
// Scoreboard bench for mem_stage. The bench uses TIMEOUT=4 and a 4-bit stall
// counter so that saturation can be reached. The driver pushes the
// hand-computed MEM/WB contents for each instruction. A monitor pops and
// compares them on every cycle in which an instruction leaves the stage.
module tb_mem_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       MEM_M;
    logic [1:0]       WB_M;
    logic [31:0]      ALUOut_M;
    logic [31:0]      WriteData_M;
    logic [4:0]       WriteReg_M;
    logic             StallM;
    logic [1:0]       WB_W;
    logic [31:0]      ReadData_W;
    logic [31:0]      ALUOut_W;
    logic [4:0]       WriteReg_W;
    logic             BusErr_W;
    logic [CNT_W-1:0] StallCount;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MEM_M       (MEM_M),
        .WB_M        (WB_M),
        .ALUOut_M    (ALUOut_M),
        .WriteData_M (WriteData_M),
        .WriteReg_M  (WriteReg_M),
        .dmem        (bus.master),
        .StallM      (StallM),
        .WB_W        (WB_W),
        .ReadData_W  (ReadData_W),
        .ALUOut_W    (ALUOut_W),
        .WriteReg_W  (WriteReg_W),
        .BusErr_W    (BusErr_W),
        .StallCount  (StallCount)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic inst_active = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Presents one instruction and works the ready line: ready stays low for
    // the first `waits` cycles. Returns at the negedge where StallM is low,
    // because that instruction leaves the stage at the next posedge.
    task automatic applyStimulus(
        input logic [1:0]  mem,
        input logic [1:0]  wb,
        input logic [31:0] alu,
        input logic [31:0] wd,
        input logic [4:0]  wreg,
        input int          waits,
        input logic [31:0] rdata,
        input logic        exp_req,
        input int          exp_stalls,
        input logic [1:0]  exp_wb,
        input logic [31:0] exp_rd,
        input logic        exp_err
    );
        exp_t e;
        int   c;
        int   stalls;
        bit   fin;
        @(posedge clk);
        #2;
        MEM_M          = mem;
        WB_M           = wb;
        ALUOut_M       = alu;
        WriteData_M    = wd;
        WriteReg_M     = wreg;
        bus.dmem_rdata = rdata;
        bus.dmem_ready = (waits == 0);
        inst_active    = 1'b1;
        e.wb   = exp_wb;
        e.rd   = exp_rd;
        e.alu  = alu;
        e.wreg = wreg;
        e.err  = exp_err;
        exp_q.push_back(e);
        c      = 0;
        stalls = 0;
        fin    = 0;
        while (!fin) begin
            @(negedge clk);
            if (c == 0) checkOutput("dmem_req_first", 32'(bus.dmem_req), 32'(exp_req));
            if (!StallM) begin
                fin = 1;
            end else if (c >= 40) begin
                checks++;
                failures++;
                $display("[TB] FAIL stall_bound actual=%0d expected=%0d", c, exp_stalls);
                fin = 1;
            end else begin
                stalls++;
                checkOutput("req_held", 32'(bus.dmem_req), 32'd1);
                checkOutput("addr_held", bus.dmem_addr, alu);
                checkOutput("we_held", 32'(bus.dmem_we), 32'(mem[0]));
                checkOutput("wdata_held", bus.dmem_wdata, wd);
                if (c > 0) checkOutput("bubble_WB_W", 32'(WB_W), 32'd0);
                @(posedge clk);
                #2;
                c++;
                bus.dmem_ready = (c >= waits);
            end
        end
        checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    // Monitor: an active instruction with StallM low at the negedge is loaded
    // into MEM/WB at the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_active && !StallM) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL retire_unexpected actual=retire expected=none");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("WB_W", 32'(WB_W), 32'(e.wb));
                    checkOutput("ReadData_W", ReadData_W, e.rd);
                    checkOutput("ALUOut_W", ALUOut_W, e.alu);
                    checkOutput("WriteReg_W", 32'(WriteReg_W), 32'(e.wreg));
                    checkOutput("BusErr_W", 32'(BusErr_W), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Hold reset with a legal load presented, so that the forced-low
        // request and stall can be seen.
        rst_n          = 1'b0;
        MEM_M          = 2'b10;
        WB_M           = 2'b11;
        ALUOut_M       = 32'h100;
        WriteData_M    = 32'h0;
        WriteReg_M     = 5'd8;
        bus.dmem_rdata = 32'h0;
        bus.dmem_ready = 1'b0;
        #12;
        checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_StallM", 32'(StallM), 32'd0);
        checkOutput("rst_WB_W", 32'(WB_W), 32'd0);
        checkOutput("rst_ReadData_W", ReadData_W, 32'd0);
        checkOutput("rst_ALUOut_W", ALUOut_W, 32'd0);
        checkOutput("rst_WriteReg_W", 32'(WriteReg_W), 32'd0);
        checkOutput("rst_BusErr_W", 32'(BusErr_W), 32'd0);
        checkOutput("rst_StallCount", 32'(StallCount), 32'd0);
        MEM_M    = 2'b00;
        WB_M     = 2'b00;
        ALUOut_M = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;

        //            mem    wb     alu       wdata     wreg waits rdata        req stl expwb  exprd        err
        applyStimulus(2'b00, 2'b00, 32'h0,    32'h0,    5'd0,  0, 32'h0,        0, 0, 2'b00, 32'h0,        0);
        applyStimulus(2'b10, 2'b11, 32'h100,  32'h0,    5'd8,  0, 32'hDEADBEEF, 1, 0, 2'b11, 32'hDEADBEEF, 0);
        applyStimulus(2'b00, 2'b10, 32'h7,    32'h0,    5'd3,  0, 32'h55555555, 0, 0, 2'b10, 32'hDEADBEEF, 0);
        applyStimulus(2'b01, 2'b00, 32'h40,   32'h1234, 5'd0,  3, 32'hCAFEF00D, 1, 3, 2'b00, 32'hDEADBEEF, 0);
        checkOutput("StallCount_store", 32'(StallCount), 32'd3);
        applyStimulus(2'b10, 2'b11, 32'h102,  32'h0,    5'd9,  0, 32'h11111111, 0, 0, 2'b00, 32'hDEADBEEF, 1);
        applyStimulus(2'b00, 2'b10, 32'h20,   32'h0,    5'd4,  0, 32'h0,        0, 0, 2'b10, 32'hDEADBEEF, 0);
        applyStimulus(2'b11, 2'b11, 32'h80,   32'h9,    5'd5,  0, 32'h0,        0, 0, 2'b00, 32'hDEADBEEF, 1);
        applyStimulus(2'b10, 2'b11, 32'h200,  32'h0,    5'd10, 99, 32'h22222222, 1, 4, 2'b00, 32'hDEADBEEF, 1);
        checkOutput("StallCount_timeout", 32'(StallCount), 32'd7);
        applyStimulus(2'b10, 2'b11, 32'h204,  32'h0,    5'd11, 2, 32'h33333333, 1, 2, 2'b11, 32'h33333333, 0);
        applyStimulus(2'b10, 2'b11, 32'h208,  32'h0,    5'd14, 99, 32'h66666666, 1, 4, 2'b00, 32'h33333333, 1);
        checkOutput("StallCount_13", 32'(StallCount), 32'd13);
        applyStimulus(2'b01, 2'b00, 32'h44,   32'hABCD, 5'd0,  3, 32'h77777777, 1, 3, 2'b00, 32'h33333333, 0);
        checkOutput("StallCount_saturate", 32'(StallCount), 32'd15);

        // Reset in the second wait cycle of a load that the scoreboard does
        // not track.
        @(posedge clk);
        #2;
        inst_active    = 1'b0;
        MEM_M          = 2'b10;
        WB_M           = 2'b11;
        ALUOut_M       = 32'h400;
        WriteReg_M     = 5'd13;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_stall", 32'(StallM), 32'd1);
        @(posedge clk);
        #3;
        checkOutput("pre_rst_req", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("midrst_StallM", 32'(StallM), 32'd0);
        checkOutput("midrst_WB_W", 32'(WB_W), 32'd0);
        checkOutput("midrst_ReadData_W", ReadData_W, 32'd0);
        checkOutput("midrst_ALUOut_W", ALUOut_W, 32'd0);
        checkOutput("midrst_WriteReg_W", 32'(WriteReg_W), 32'd0);
        checkOutput("midrst_BusErr_W", 32'(BusErr_W), 32'd0);
        checkOutput("midrst_StallCount", 32'(StallCount), 32'd0);
        @(negedge clk);
        MEM_M    = 2'b00;
        WB_M     = 2'b00;
        ALUOut_M = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b10, 2'b11, 32'h300,  32'h0,    5'd12, 1, 32'h44444444, 1, 1, 2'b11, 32'h44444444, 0);
        checkOutput("StallCount_after_rst", 32'(StallCount), 32'd1);
        applyStimulus(2'b00, 2'b00, 32'h0,    32'h0,    5'd0,  0, 32'h0,        0, 0, 2'b00, 32'h44444444, 0);

        @(posedge clk);
        #2;
        inst_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
